// File: rtl/serial_endpoint_pkg.sv
// Shared state encodings and address helpers for the serial endpoint.
// No timing of its own; imported by the endpoint and its TX queue.
package serial_endpoint_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_GAP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_SHIFT,
    RX_CHECK
  } rx_state_t;

  // Broadcast destination: all ones in the low addr_w bits.
  function automatic logic [63:0] broadcast_addr(input int unsigned addr_w);
    logic [63:0] ones;
    ones = '1;
    return ones >> (64 - addr_w);
  endfunction

endpackage

// File: rtl/serial_endpoint_frame_fifo.sv
// Synchronous frame queue, head visible on dout; push/pop take effect on the clock edge.
// Push while full and pop while empty are ignored; level counts held frames.
module frame_fifo
  import serial_endpoint_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign level   = count;
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/serial_endpoint.sv
// Queued 1-bit frame serializer plus address-filtering deserializer; push-to-rx_valid over loopback is FRAME_W+3 cycles.
// tx_ready drops when the queue is full; SERIAL_ENDPOINT_PROMISC_EN adds a promisc input that skips the destination check.
module serial_endpoint
  import serial_endpoint_pkg::*;
#(
  parameter int                FRAME_W     = 16,
  parameter int                SFD_W       = 4,
  parameter int                ADDR_W      = 4,
  parameter logic [SFD_W-1:0]  SFD_PATTERN = 4'hA,
  parameter logic [ADDR_W-1:0] MAC_ADDRESS = '0,
  parameter int                TXQ_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [FRAME_W-1:0]           tx_frame,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic [$clog2(TXQ_DEPTH):0]   tx_level,
  output logic                         tx_bit,
  output logic                         tx_busy,
  input  logic                         rx_bit,
`ifdef SERIAL_ENDPOINT_PROMISC_EN
  input  logic                         promisc,
`endif
  output logic [FRAME_W-1:0]           rx_frame,
  output logic                         rx_valid,
  output logic [7:0]                   rx_drop_cnt
);

  localparam int                CNT_W = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(FRAME_W - 1);
  localparam logic [ADDR_W-1:0] BCAST = ADDR_W'(broadcast_addr(ADDR_W));

  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic [FRAME_W-1:0] fifo_dout;

  tx_state_t          tx_state, tx_state_nxt;
  logic [FRAME_W-1:0] tx_sh, tx_sh_nxt;
  logic [CNT_W-1:0]   tx_cnt, tx_cnt_nxt;
  logic               tx_bit_nxt;

  rx_state_t          rx_state, rx_state_nxt;
  logic [FRAME_W-1:0] rx_sh, rx_sh_nxt;
  logic [CNT_W-1:0]   rx_cnt, rx_cnt_nxt;
  logic               rx_prev;
  logic [FRAME_W-1:0] rx_frame_nxt;
  logic               rx_valid_nxt;
  logic [7:0]         rx_drop_nxt;
  logic [SFD_W-1:0]   rx_sfd;
  logic [ADDR_W-1:0]  rx_dst;
  logic               sfd_ok;
  logic               addr_ok;

  assign tx_ready = !fifo_full;
  assign tx_busy  = (tx_state == TX_START) || (tx_state == TX_DATA);

  frame_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (TXQ_DEPTH)
  ) u_txq (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_valid && tx_ready),
    .din   (tx_frame),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (tx_level)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state <= TX_IDLE;
      tx_sh    <= '0;
      tx_cnt   <= '0;
      tx_bit   <= 1'b1;
    end else begin
      tx_state <= tx_state_nxt;
      tx_sh    <= tx_sh_nxt;
      tx_cnt   <= tx_cnt_nxt;
      tx_bit   <= tx_bit_nxt;
    end
  end

  // A pending frame leaves GAP straight for START so back-to-back frames keep a single idle bit.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_sh_nxt    = tx_sh;
    tx_cnt_nxt   = tx_cnt;
    tx_bit_nxt   = 1'b1;
    fifo_pop     = 1'b0;
    unique case (tx_state)
      TX_IDLE, TX_GAP: begin
        if (!fifo_empty) begin
          fifo_pop     = 1'b1;
          tx_sh_nxt    = fifo_dout;
          tx_bit_nxt   = 1'b0;
          tx_state_nxt = TX_START;
        end else begin
          tx_state_nxt = TX_IDLE;
        end
      end
      TX_START: begin
        tx_bit_nxt   = tx_sh[FRAME_W-1];
        tx_sh_nxt    = {tx_sh[FRAME_W-2:0], 1'b0};
        tx_cnt_nxt   = '0;
        tx_state_nxt = TX_DATA;
      end
      TX_DATA: begin
        if (tx_cnt == LAST) begin
          tx_state_nxt = TX_GAP;
        end else begin
          tx_bit_nxt = tx_sh[FRAME_W-1];
          tx_sh_nxt  = {tx_sh[FRAME_W-2:0], 1'b0};
          tx_cnt_nxt = tx_cnt + 1'b1;
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  assign rx_sfd = rx_sh[FRAME_W-1 -: SFD_W];
  assign rx_dst = rx_sh[FRAME_W-SFD_W-1 -: ADDR_W];
  assign sfd_ok = (rx_sfd == SFD_PATTERN);

`ifdef SERIAL_ENDPOINT_PROMISC_EN
  assign addr_ok = promisc || (rx_dst == MAC_ADDRESS) || (rx_dst == BCAST);
`else
  assign addr_ok = (rx_dst == MAC_ADDRESS) || (rx_dst == BCAST);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_state    <= RX_IDLE;
      rx_sh       <= '0;
      rx_cnt      <= '0;
      rx_prev     <= 1'b1;
      rx_frame    <= '0;
      rx_valid    <= 1'b0;
      rx_drop_cnt <= '0;
    end else begin
      rx_state    <= rx_state_nxt;
      rx_sh       <= rx_sh_nxt;
      rx_cnt      <= rx_cnt_nxt;
      rx_prev     <= rx_bit;
      rx_frame    <= rx_frame_nxt;
      rx_valid    <= rx_valid_nxt;
      rx_drop_cnt <= rx_drop_nxt;
    end
  end

  // Only a 1->0 transition starts a frame, so a stuck-low line cannot retrigger.
  always_comb begin
    rx_state_nxt = rx_state;
    rx_sh_nxt    = rx_sh;
    rx_cnt_nxt   = rx_cnt;
    rx_frame_nxt = rx_frame;
    rx_valid_nxt = 1'b0;
    rx_drop_nxt  = rx_drop_cnt;
    unique case (rx_state)
      RX_IDLE: begin
        if (!rx_bit && rx_prev) begin
          rx_cnt_nxt   = '0;
          rx_state_nxt = RX_SHIFT;
        end
      end
      RX_SHIFT: begin
        rx_sh_nxt  = {rx_sh[FRAME_W-2:0], rx_bit};
        rx_cnt_nxt = rx_cnt + 1'b1;
        if (rx_cnt == LAST) begin
          rx_state_nxt = RX_CHECK;
        end
      end
      RX_CHECK: begin
        rx_state_nxt = RX_IDLE;
        if (sfd_ok && addr_ok) begin
          rx_frame_nxt = rx_sh;
          rx_valid_nxt = 1'b1;
        end else if (rx_drop_cnt != 8'hFF) begin
          rx_drop_nxt = rx_drop_cnt + 8'd1;
        end
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_endpoint.sv
// Loopback bench for serial_endpoint: directed timing steps plus randomized frames scored against a rule-based model.
module tb_serial_endpoint;

  localparam int FW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [FW-1:0] tx_frame = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [2:0]    tx_level;
  logic          tx_bit;
  logic          tx_busy;
  logic          force_low = 1'b0;
  logic          rx_line;
  logic [FW-1:0] rx_frame;
  logic          rx_valid;
  logic [7:0]    rx_drop_cnt;
  bit            prom = 1'b0;
`ifdef SERIAL_ENDPOINT_PROMISC_EN
  logic          promisc = 1'b0;
`endif

  assign rx_line = tx_bit & ~force_low;

  serial_endpoint #(
    .FRAME_W     (FW),
    .SFD_W       (4),
    .ADDR_W      (4),
    .SFD_PATTERN (4'hA),
    .MAC_ADDRESS (4'h3),
    .TXQ_DEPTH   (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_frame    (tx_frame),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_level    (tx_level),
    .tx_bit      (tx_bit),
    .tx_busy     (tx_busy),
    .rx_bit      (rx_line),
`ifdef SERIAL_ENDPOINT_PROMISC_EN
    .promisc     (promisc),
`endif
    .rx_frame    (rx_frame),
    .rx_valid    (rx_valid),
    .rx_drop_cnt (rx_drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [FW-1:0] rx_q[$];
  int            rx_t[$];
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_q.push_back(rx_frame);
      rx_t.push_back(cyc);
    end
  end

  int npass  = 0;
  int ncheck = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ncheck++;
    assert (got === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Acceptance rule: delimiter must match; destination must be ours or broadcast unless promiscuous.
  function automatic bit accepts(input logic [FW-1:0] f, input bit p);
    logic [3:0] sfd;
    logic [3:0] dst;
    sfd = f[15:12];
    dst = f[11:8];
    return (sfd == 4'hA) && (p || dst == 4'h3 || dst == 4'hF);
  endfunction

  function automatic logic [FW-1:0] qget(input int i);
    if (i < rx_q.size()) return rx_q[i];
    return 'x;
  endfunction

  function automatic int tget(input int i);
    if (i < rx_t.size()) return rx_t[i];
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    rx_q.delete();
    rx_t.delete();
  endtask

  task automatic push(input logic [FW-1:0] f, output int e);
    int n;
    n = 0;
    tx_frame = f;
    tx_valid = 1'b1;
    while (!tx_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("push_wait", 1'b0, 1'b1);
    tick();
    e = cyc;
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((tx_level != 0 || tx_busy) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) chk({tag, "_drain"}, 1'b0, 1'b1);
    repeat (4) tick();
  endtask

  initial begin
    int            e;
    int            e2;
    int            e0;
    int            e6;
    int            idx;
    bit            rdy;
    bit            chkd;
    int            exp_drop;
    logic [FW-1:0] f;
    logic [FW-1:0] fr[6];
    logic [FW-1:0] exp_q[$];
    logic [3:0]    sfd;
    logic [3:0]    dst;
    int            pick;

    // Reset state while rst is held low.
    tick();
    tick();
    chk("rst_tx_bit", tx_bit, 1'b1);
    chk("rst_level", tx_level, 3'd0);
    chk("rst_ready", tx_ready, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_rx_frame", rx_frame, 16'h0);
    chk("rst_drop", rx_drop_cnt, 8'd0);
    rst = 1'b1;
    tick();

    // Single frame: bit-exact line waveform and loopback latency.
    f = 16'hA35C;
    push(f, e);
    tick();
    chk("start_bit", tx_bit, 1'b0);
    chk("busy_start", tx_busy, 1'b1);
    for (int k = 0; k < FW; k++) begin
      tick();
      chk($sformatf("data_bit%0d", k), tx_bit, f[FW-1-k]);
    end
    tick();
    chk("stop_idle", tx_bit, 1'b1);
    chk("busy_gap", tx_busy, 1'b0);
    tick();
    chk("rx_valid_pulse", rx_valid, 1'b1);
    chk("rx_frame_a35c", rx_frame, f);
    chk("rx_latency", cyc - e, 19);
    tick();
    chk("rx_valid_one_cycle", rx_valid, 1'b0);
    chk("drop_zero", rx_drop_cnt, 8'd0);

    // Wrong destination dropped, broadcast accepted.
    wait_idle("t1");
    rx_q.delete();
    rx_t.delete();
    push(16'hA75C, e);
    push(16'hAF5C, e2);
    wait_idle("bcast");
    chk("bcast_count", rx_q.size(), 1);
    chk("bcast_frame", qget(0), 16'hAF5C);
    chk("bcast_drop", rx_drop_cnt, 8'd1);
    chk("bcast_hold", rx_frame, 16'hAF5C);

    // Bad delimiter.
    do_reset();
    chk("sfd_rst_frame", rx_frame, 16'h0);
    push(16'h535C, e);
    wait_idle("sfd");
    chk("sfd_no_valid", rx_q.size(), 0);
    chk("sfd_drop", rx_drop_cnt, 8'd1);
    chk("sfd_hold", rx_frame, 16'h0);

    // Queue fill with tx_valid held high, then ordered reception 18 cycles apart.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      fr[i] = {4'hA, (i % 2 == 1) ? 4'hF : 4'h3, 4'(i), 4'($urandom)};
    end
    idx = 0;
    chkd = 1'b0;
    e0 = -1;
    e6 = -1;
    tx_frame = fr[0];
    tx_valid = 1'b1;
    for (int n = 0; n < 100 && idx < 6; n++) begin
      rdy = tx_ready;
      tick();
      if (rdy) begin
        if (idx == 0) e0 = cyc;
        if (idx == 5) e6 = cyc;
        idx++;
        if (idx < 6) tx_frame = fr[idx];
        else tx_valid = 1'b0;
      end
      if (idx == 5 && !chkd) begin
        chk("full_ready", tx_ready, 1'b0);
        chk("full_level", tx_level, 3'd4);
        chk("full_edge", cyc - e0, 4);
        chkd = 1'b1;
      end
    end
    tx_valid = 1'b0;
    chk("fill_pushed", idx, 6);
    chk("sixth_push_edge", e6 - e0, 20);
    wait_idle("fill");
    chk("fill_rx_count", rx_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("fill_frame%0d", i), qget(i), fr[i]);
      chk($sformatf("fill_time%0d", i), tget(i) - e0, 19 + 18 * i);
    end

    // Randomized frames against the acceptance model.
    do_reset();
    exp_drop = 0;
    exp_q.delete();
    for (int i = 0; i < 12; i++) begin
      sfd = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hA;
      pick = $urandom_range(0, 2);
      dst = (pick == 0) ? 4'h3 : (pick == 1) ? 4'hF : 4'($urandom);
      f = {sfd, dst, 8'($urandom)};
      if (accepts(f, prom)) exp_q.push_back(f);
      else exp_drop++;
      push(f, e);
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_idle("rand");
    chk("rand_count", rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("rand_frame%0d", i), qget(i), exp_q[i]);
    end
    chk("rand_drop", rx_drop_cnt, 8'(exp_drop));

    // Line held low: one reception, no restart until a fresh falling edge.
    do_reset();
    force_low = 1'b1;
    repeat (40) tick();
    force_low = 1'b0;
    repeat (25) tick();
    chk("low_drop", rx_drop_cnt, 8'd1);
    chk("low_no_valid", rx_q.size(), 0);

    // Reset during data bit 5 aborts both directions.
    do_reset();
    f = 16'hA35C;
    push(f, e);
    push(16'hAF11, e2);
    chk("abort_level", tx_level, 3'd1);
    repeat (6) tick();
    chk("abort_bit5", tx_bit, f[FW-1-5]);
    chk("abort_edge", cyc - e, 7);
    rst = 1'b0;
    tick();
    chk("abort_tx_bit", tx_bit, 1'b1);
    chk("abort_level0", tx_level, 3'd0);
    chk("abort_ready", tx_ready, 1'b1);
    chk("abort_busy", tx_busy, 1'b0);
    rst = 1'b1;
    repeat (30) tick();
    chk("abort_no_valid", rx_q.size(), 0);
    chk("abort_drop", rx_drop_cnt, 8'd0);
    chk("abort_idle_line", tx_bit, 1'b1);

`ifdef SERIAL_ENDPOINT_PROMISC_EN
    // Promiscuous mode skips destination but keeps delimiter check.
    do_reset();
    promisc = 1'b1;
    prom = 1'b1;
    push(16'hA75C, e);
    wait_idle("prom1");
    chk("prom_accept_count", rx_q.size(), 1);
    chk("prom_accept_frame", qget(0), 16'hA75C);
    push(16'h575C, e);
    wait_idle("prom2");
    chk("prom_bad_sfd_count", rx_q.size(), 1);
    chk("prom_drop", rx_drop_cnt, 8'd1);
    promisc = 1'b0;
    prom = 1'b0;
`endif

    // Drop counter saturation via single-cycle low pulses (all-ones frames fail the delimiter).
    do_reset();
    for (int i = 0; i < 260; i++) begin
      force_low = 1'b1;
      tick();
      force_low = 1'b0;
      repeat (19) tick();
      if (i == 99) chk("drop_100", rx_drop_cnt, 8'd100);
    end
    chk("drop_saturate", rx_drop_cnt, 8'd255);
    chk("sat_no_valid", rx_q.size(), 0);

    $display("%0d/%0d checks passed", npass, ncheck);
    $finish;
  end

endmodule
